// File: rtl/vga_monitor_pkg.sv
// rtl/vga_monitor_pkg.sv - mode timing defaults, FSM states and helpers for vga_monitor
package vga_monitor_pkg;

  // 640x480@60 timing, same values vga_controller is built with
  localparam int MODE_H_ACTIVE = 640;
  localparam int MODE_H_FRONT  = 16;
  localparam int MODE_H_SYNC   = 96;
  localparam int MODE_H_BACK   = 48;
  localparam int MODE_V_ACTIVE = 480;
  localparam int MODE_V_FRONT  = 10;
  localparam int MODE_V_SYNC   = 2;
  localparam int MODE_V_BACK   = 33;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_e;

  function automatic logic [9:0] sat_inc10(input logic [9:0] value);
    return (value == 10'h3FF) ? value : value + 10'd1;
  endfunction

endpackage

// File: rtl/crc16_step.sv
// rtl/crc16_step.sv - one-byte CRC-16-CCITT (poly 0x1021) update, MSB first
// Only present when VGA_MONITOR_CHECKSUM_EN is defined.
`ifdef VGA_MONITOR_CHECKSUM_EN
module crc16_step (
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  logic [7:0] x0;
  logic [7:0] x1;

  // byte-at-a-time form of the 0x1021 division: x^12, x^5, x^0 taps of the folded byte
  always_comb begin
    x0       = crc[15:8] ^ data;
    x1       = x0 ^ (x0 >> 4);
    crc_next = {crc[7:0], 8'h00} ^ {x1[3:0], 12'h000} ^ {3'b000, x1, 5'b00000} ^ {8'h00, x1};
  end

endmodule
`endif

// File: rtl/vga_monitor.sv
// rtl/vga_monitor.sv - VGA sink: recovers pixel coordinates, checks sync timing, reports lock
// Optional frame CRC-16 checksum enabled by VGA_MONITOR_CHECKSUM_EN.
module vga_monitor
  import vga_monitor_pkg::*;
#(
  parameter int H_ACTIVE = MODE_H_ACTIVE,
  parameter int H_FRONT  = MODE_H_FRONT,
  parameter int H_SYNC   = MODE_H_SYNC,
  parameter int H_BACK   = MODE_H_BACK,
  parameter int V_ACTIVE = MODE_V_ACTIVE,
  parameter int V_FRONT  = MODE_V_FRONT,
  parameter int V_SYNC   = MODE_V_SYNC,
  parameter int V_BACK   = MODE_V_BACK,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  vga_color,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_color,
  output logic        frame_done,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] frame_count,
  output logic [15:0] checksum
);

  localparam logic        ACT       = (SYNC_POL != 0);
  localparam logic [10:0] H_TOTAL_L = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [10:0] V_TOTAL_L = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [10:0] H_SYNC_L  = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_L  = 11'(V_SYNC);
  localparam logic [9:0]  X_START   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  X_END     = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  Y_START   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  Y_END     = 10'(V_SYNC + V_BACK + V_ACTIVE);

  logic       hs_q1, hs_q2, vs_q1, vs_q2;
  logic [7:0] col_q1, col_q2;
  logic       hs_lead, hs_trail, vs_lead, vs_trail;

  mon_state_e state, state_nxt;
  logic [9:0]  hcount, vcount;
  logic        vs_pend;
  logic        h_per_arm, h_wid_arm, v_arm;
  logic [10:0] vs_width;
  logic [10:0] h_meas, v_meas;
  logic        h_sat, v_sat, h_evt, v_evt, checking, err;

  logic       pix_valid_c;
  logic [9:0] x_cur, y_cur, x_hold, y_hold;
  logic [7:0] c_hold;

  // edges are judged between the two register stages so hcount lines up with col_q2
  assign hs_lead  = (hs_q1 == ACT) && (hs_q2 != ACT);
  assign hs_trail = (hs_q1 != ACT) && (hs_q2 == ACT);
  assign vs_lead  = (vs_q1 == ACT) && (vs_q2 != ACT);
  assign vs_trail = (vs_q1 != ACT) && (vs_q2 == ACT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_q1  <= ~ACT;
      hs_q2  <= ~ACT;
      vs_q1  <= ~ACT;
      vs_q2  <= ~ACT;
      col_q1 <= 8'h00;
      col_q2 <= 8'h00;
    end else begin
      hs_q1  <= hsync;
      hs_q2  <= hs_q1;
      vs_q1  <= vsync;
      vs_q2  <= vs_q1;
      col_q1 <= vga_color;
      col_q2 <= col_q1;
    end
  end

  assign h_meas   = {1'b0, hcount} + 11'd1;
  assign v_meas   = {1'b0, vcount} + 11'd1;
  assign h_sat    = !hs_lead && (hcount == 10'd1022);
  assign v_sat    = hs_lead && !(vs_lead || vs_pend) && (vcount == 10'd1022);
  assign h_evt    = (hs_lead && h_per_arm && (h_meas != H_TOTAL_L))
                 || (hs_trail && h_wid_arm && (h_meas != H_SYNC_L))
                 || h_sat;
  assign v_evt    = (vs_lead && v_arm && ((v_meas != V_TOTAL_L) || (vs_width != V_SYNC_L)))
                 || v_sat;
  assign checking = (state != ST_SEARCH);
  assign err      = checking && (h_evt || v_evt);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_SEARCH:  if (vs_lead) state_nxt = ST_MEASURE;
      ST_MEASURE: begin
        if (err)          state_nxt = ST_SEARCH;
        else if (vs_lead) state_nxt = ST_LOCKED;
      end
      ST_LOCKED:  if (err) state_nxt = ST_SEARCH;
      default:    state_nxt = ST_SEARCH;
    endcase
  end

  assign locked = (state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_SEARCH;
      hcount      <= 10'd0;
      vcount      <= 10'd0;
      vs_pend     <= 1'b0;
      vs_width    <= 11'd0;
      h_per_arm   <= 1'b0;
      h_wid_arm   <= 1'b0;
      v_arm       <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      state  <= state_nxt;
      hcount <= hs_lead ? 10'd0 : sat_inc10(hcount);

      if (hs_lead) begin
        vcount  <= (vs_lead || vs_pend) ? 10'd0 : sat_inc10(vcount);
        vs_pend <= 1'b0;
      end else if (vs_lead) begin
        vs_pend <= 1'b1;
      end

      if (vs_lead)       vs_width <= 11'd0;
      else if (vs_trail) vs_width <= v_meas;

      // the measurement that leaves SEARCH only arms the checks that follow it
      if (state == ST_SEARCH) begin
        h_per_arm <= vs_lead && hs_lead;
        h_wid_arm <= vs_lead && hs_trail;
        v_arm     <= vs_lead;
      end else begin
        h_per_arm <= h_per_arm || hs_lead;
        h_wid_arm <= h_wid_arm || hs_trail;
        v_arm     <= v_arm || vs_lead;
      end

      h_err      <= h_err || (checking && h_evt);
      v_err      <= v_err || (checking && v_evt);
      frame_done <= vs_lead;
      if (vs_lead) frame_count <= frame_count + 16'd1;
    end
  end

  assign x_cur       = hcount - X_START;
  assign y_cur       = vcount - Y_START;
  assign pix_valid_c = locked && (hcount >= X_START) && (hcount < X_END)
                    && (vcount >= Y_START) && (vcount < Y_END);

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_hold <= 10'd0;
      y_hold <= 10'd0;
      c_hold <= 8'h00;
    end else if (pix_valid_c) begin
      x_hold <= x_cur;
      y_hold <= y_cur;
      c_hold <= col_q2;
    end
  end

  assign pix_valid = pix_valid_c;
  assign pix_x     = pix_valid_c ? x_cur  : x_hold;
  assign pix_y     = pix_valid_c ? y_cur  : y_hold;
  assign pix_color = pix_valid_c ? col_q2 : c_hold;

`ifdef VGA_MONITOR_CHECKSUM_EN
  logic [15:0] crc_acc, crc_nxt, checksum_q;

  crc16_step u_crc16_step (
    .crc      (crc_acc),
    .data     (col_q2),
    .crc_next (crc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_acc    <= CRC_INIT;
      checksum_q <= 16'h0000;
    end else if (vs_lead) begin
      checksum_q <= pix_valid_c ? crc_nxt : crc_acc;
      crc_acc    <= CRC_INIT;
    end else if (pix_valid_c) begin
      crc_acc    <= crc_nxt;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_monitor.sv
// tb/tb_vga_monitor.sv - directed self-checking bench for vga_monitor on a reduced video mode
module tb_vga_monitor;

  localparam int HA = 16, HF = 4, HS = 8, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [7:0]  vga_color = 8'h00;
  logic        pix_valid, frame_done, locked, h_err, v_err;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_color;
  logic [15:0] frame_count, checksum;

  vga_monitor #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .vga_color(vga_color),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .frame_done(frame_done), .locked(locked), .h_err(h_err), .v_err(v_err),
    .frame_count(frame_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_valid, pix_bad, first_x, first_y, last_x, last_y, first_valid_cyc, drv00_cyc;
  int n_fd, lock_fall_cyc, herr_cyc, verr_cyc, lead_drv_cyc, last_lead_cyc, nfr;
  int vs_drv [8];
  int fd_cyc [8];
  logic [7:0] fd_locked;
  logic lock_seen, prev_locked;
  logic act_p [2];
  int x_p [2];
  int y_p [2];
  logic [7:0] col_p [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

`ifdef VGA_MONITOR_CHECKSUM_EN
  function automatic logic [15:0] crc_ref(input logic [7:0] b, input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++)
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ b[i];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction
`endif

  task automatic clear_obs();
    n_valid = 0; pix_bad = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    first_valid_cyc = -1; drv00_cyc = -1; n_fd = 0; lock_fall_cyc = -1;
    herr_cyc = -1; verr_cyc = -1; lead_drv_cyc = -1; nfr = 0;
    fd_locked = 8'h00; lock_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin vs_drv[i] = -1; fd_cyc[i] = -1; end
  endtask

  // one clock: observe at the falling edge, then drive the next input sample
  task automatic step(input logic h, input logic v, input logic [7:0] c,
                      input logic act, input int x, input int y);
    @(negedge clk);
    if (frame_done) begin
      if (n_fd < 8) begin fd_locked[n_fd] = locked; fd_cyc[n_fd] = cyc; end
      n_fd++;
    end
    if (locked) lock_seen = 1'b1;
    if (prev_locked && !locked && lock_fall_cyc < 0) lock_fall_cyc = cyc;
    prev_locked = locked;
    if (h_err && herr_cyc < 0) herr_cyc = cyc;
    if (v_err && verr_cyc < 0) verr_cyc = cyc;
    if (pix_valid) begin
      if (n_valid == 0) begin first_valid_cyc = cyc; first_x = int'(pix_x); first_y = int'(pix_y); end
      n_valid++;
      last_x = int'(pix_x);
      last_y = int'(pix_y);
      if (!act_p[1] || int'(pix_x) != x_p[1] || int'(pix_y) != y_p[1] || pix_color != col_p[1])
        pix_bad++;
    end
    act_p[1] = act_p[0]; x_p[1] = x_p[0]; y_p[1] = y_p[0]; col_p[1] = col_p[0];
    act_p[0] = act;      x_p[0] = x;      y_p[0] = y;      col_p[0] = c;
    hsync = h; vsync = v; vga_color = c;
    cyc++;
  endtask

  task automatic drive_frame(input int n_lines, input int long_line, input int extra,
                             input logic [7:0] col);
    for (int l = 0; l < n_lines; l++) begin
      int len;
      len = HT + ((l == long_line) ? extra : 0);
      for (int p = 0; p < len; p++) begin
        logic a;
        a = (p >= HS + HB) && (p < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
        if (p == 0) last_lead_cyc = cyc;
        if (l == 0 && p == 0) begin
          if (nfr < 8) vs_drv[nfr] = cyc;
          nfr++;
        end
        if (long_line >= 0 && l == long_line + 1 && p == 0) lead_drv_cyc = cyc;
        if (a && drv00_cyc < 0) drv00_cyc = cyc;
        step((p < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, a ? col : 8'h00,
             a, p - (HS + HB), l - (VS + VB));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (4) step(1'b1, 1'b1, 8'h00, 1'b0, 0, 0);
  endtask

  initial begin
    prev_locked = 1'b0;
    act_p[0] = 1'b0; act_p[1] = 1'b0;
    x_p[0] = 0; x_p[1] = 0; y_p[0] = 0; y_p[1] = 0; col_p[0] = 8'h00; col_p[1] = 8'h00;
    clear_obs();

    // reset state
    do_reset();
    check("rst_locked", locked, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_h_err", h_err, 0);
    check("rst_v_err", v_err, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_checksum", checksum, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_color", pix_color, 0);
    rst = 1'b1;

    // three clean frames: lock at the second frame_done
    clear_obs();
    repeat (3) drive_frame(VT, -1, 0, 8'h00);
    check("lock_fd1", fd_locked[0], 0);
    check("lock_fd2", fd_locked[1], 1);
    check("lock_frame_count", frame_count, 3);
    check("lock_fd_latency", fd_cyc[0] - vs_drv[0], 2);
    check("lock_locked", locked, 1);
    check("lock_h_err", h_err, 0);
    check("lock_v_err", v_err, 0);
    check("lock_valid_count", n_valid, 2 * HA * VA);
    check("lock_pix_bad", pix_bad, 0);
`ifdef VGA_MONITOR_CHECKSUM_EN
    check("checksum_zero_frame", checksum, crc_ref(8'h00, HA * VA));
`else
    check("checksum_off", checksum, 0);
`endif

    // constant 0xA5 frame while locked
    clear_obs();
    drive_frame(VT, -1, 0, 8'hA5);
    check("a5_valid_count", n_valid, HA * VA);
    check("a5_pix_bad", pix_bad, 0);
    check("a5_first_x", first_x, 0);
    check("a5_first_y", first_y, 0);
    check("a5_first_latency", first_valid_cyc - drv00_cyc, 2);
    check("a5_last_x", last_x, HA - 1);
    check("a5_last_y", last_y, VA - 1);
    check("a5_hold_valid", pix_valid, 0);
    check("a5_hold_x", pix_x, HA - 1);
    check("a5_hold_y", pix_y, VA - 1);
    check("a5_hold_color", pix_color, 8'hA5);
    check("a5_frame_count", frame_count, 4);

    // one line stretched by a clock while locked, then relock
    clear_obs();
    drive_frame(VT, 5, 1, 8'h3C);
    check("stretch_herr_cyc", herr_cyc - lead_drv_cyc, 2);
    check("stretch_unlock_cyc", lock_fall_cyc - lead_drv_cyc, 2);
    check("stretch_v_err", v_err, 0);
    check("stretch_pix_bad", pix_bad, 0);
    clear_obs();
    repeat (2) drive_frame(VT, -1, 0, 8'h00);
    check("relock_fd1", fd_locked[0], 0);
    check("relock_fd2", fd_locked[1], 1);
    check("relock_locked", locked, 1);
    check("relock_h_err_sticky", h_err, 1);
    check("relock_frame_count", frame_count, 7);

    // hsync held deasserted: hcount saturation
    do_reset();
    rst = 1'b1;
    clear_obs();
    repeat (2) drive_frame(VT, -1, 0, 8'h00);
    check("sat_locked_before", locked, 1);
    repeat (1100) step(1'b1, 1'b1, 8'h00, 1'b0, 0, 0);
    check("sat_herr_cyc", herr_cyc - last_lead_cyc, 1025);
    check("sat_unlock_cyc", lock_fall_cyc - last_lead_cyc, 1025);
    check("sat_locked", locked, 0);
    check("sat_v_err", v_err, 0);

    // short frames never lock
    do_reset();
    rst = 1'b1;
    clear_obs();
    repeat (4) drive_frame(VT - 1, -1, 0, 8'h00);
    check("short_v_err", v_err, 1);
    check("short_verr_cyc", verr_cyc - vs_drv[1], 2);
    check("short_never_locked", lock_seen, 0);
    check("short_h_err", h_err, 0);
    check("short_frame_count", frame_count, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
